// File: rtl/fpu_half_issue_ctrl.sv
// Half-precision FPU issue/writeback control: routes ops to the pipe or the
// iterative unit, blocks RAW/WAW on an rd scoreboard, and arbitrates the single
// writeback port. The pipe always wins writeback; the iterative result waits.
// Ports: CLK, rst (sync, high); req_* handshake; pipe_issue/pipe_op;
//   iter_start/iter_sqrt/iter_done; wb_valid/wb_rd/wb_sel.
// FPU_ISSUE_PERF_EN adds perf_issue_cnt/perf_stall_cnt.
package fpu_half_pkg;
  typedef enum logic [3:0] {
    FPU_HALF_ADD,
    FPU_HALF_SUB,
    FPU_HALF_MUL,
    FPU_HALF_DIV,
    FPU_HALF_SQRT,
    FPU_HALF_MADD,
    FPU_HALF_MSUB,
    FPU_HALF_NMADD,
    FPU_HALF_NMSUB,
    FPU_HALF_MIN,
    FPU_HALF_MAX,
    FPU_HALF_CMP,
    FPU_HALF_CVT
  } fpu_operation_t;
endpackage

module fpu_half_issue_ctrl
  import fpu_half_pkg::*;
#(
  parameter int PIPE_LAT = 3,
  parameter int REG_W    = 5
) (
  input  logic                               CLK,
  input  logic                               rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [$bits(fpu_operation_t)-1:0]  req_op,
  input  logic [REG_W-1:0]                   req_rd,
  input  logic [REG_W-1:0]                   req_rs1,
  input  logic [REG_W-1:0]                   req_rs2,
  input  logic [REG_W-1:0]                   req_rs3,
  output logic                               pipe_issue,
  output logic [$bits(fpu_operation_t)-1:0]  pipe_op,
  output logic                               iter_start,
  output logic                               iter_sqrt,
  input  logic                               iter_done,
  output logic                               wb_valid,
  output logic [REG_W-1:0]                   wb_rd,
  output logic                               wb_sel
`ifdef FPU_ISSUE_PERF_EN
  ,
  output logic [31:0]                        perf_issue_cnt,
  output logic [31:0]                        perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE_WAIT
  } state_t;

  state_t              state, state_nx;
  fpu_operation_t      op;
  logic [PIPE_LAT-1:0] pv;
  logic [REG_W-1:0]    prd [PIPE_LAT];
  logic [REG_W-1:0]    iter_rd;
  logic                is_iter;
  logic                is_fma;
  logic                hazard;
  logic                acc;
  logic                tail_v;

  // x0 never matches: a zero candidate is excluded up front.
  function automatic logic clash(
    input logic [REG_W-1:0] c,
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] rs1,
    input logic [REG_W-1:0] rs2,
    input logic [REG_W-1:0] rs3,
    input logic             fma
  );
    return (c != '0) &&
           (c == rd || c == rs1 || c == rs2 ||
            (fma && c == rs3));
  endfunction

  assign op      = fpu_operation_t'(req_op);
  assign is_iter = (op == FPU_HALF_DIV) ||
                   (op == FPU_HALF_SQRT);
  assign is_fma  = (op == FPU_HALF_MADD) ||
                   (op == FPU_HALF_MSUB) ||
                   (op == FPU_HALF_NMADD) ||
                   (op == FPU_HALF_NMSUB);
  assign tail_v  = pv[PIPE_LAT-1];

  // Tail counts as in flight even while it writes back.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < PIPE_LAT; i++) begin
      if (pv[i] && clash(prd[i], req_rd, req_rs1,
                         req_rs2, req_rs3, is_fma))
        hazard = 1'b1;
    end
    if (state != IDLE &&
        clash(iter_rd, req_rd, req_rs1,
              req_rs2, req_rs3, is_fma))
      hazard = 1'b1;
  end

  // DONE_WAIT holds off pipe issue so the iterative
  // result drains within PIPE_LAT cycles.
  always_comb begin
    if (is_iter)
      req_ready = !hazard && (state == IDLE);
    else
      req_ready = !hazard && (state != DONE_WAIT);
  end

  assign acc        = req_valid && req_ready;
  assign pipe_issue = acc && !is_iter;
  assign pipe_op    = req_op;
  assign iter_start = acc && is_iter;
  assign iter_sqrt  = iter_start &&
                      (op == FPU_HALF_SQRT);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (iter_start) state_nx = BUSY;
      BUSY:      if (iter_done)  state_nx = DONE_WAIT;
      DONE_WAIT: if (!tail_v)    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      pv      <= '0;
      state   <= IDLE;
      iter_rd <= '0;
    end else begin
      pv[0] <= pipe_issue;
      for (int i = 1; i < PIPE_LAT; i++)
        pv[i] <= pv[i-1];
      state <= state_nx;
      if (iter_start)
        iter_rd <= req_rd;
    end
  end

  always_ff @(posedge CLK) begin
    prd[0] <= req_rd;
    for (int i = 1; i < PIPE_LAT; i++)
      prd[i] <= prd[i-1];
  end

  always_comb begin
    wb_valid = 1'b0;
    wb_sel   = 1'b0;
    wb_rd    = '0;
    if (tail_v) begin
      wb_valid = 1'b1;
      wb_rd    = prd[PIPE_LAT-1];
    end else if (state == DONE_WAIT) begin
      wb_valid = 1'b1;
      wb_sel   = 1'b1;
      wb_rd    = iter_rd;
    end
  end

`ifdef FPU_ISSUE_PERF_EN
  always_ff @(posedge CLK) begin
    if (rst) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (acc)
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (req_valid && !req_ready)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_half_issue_ctrl.sv
// Bench for fpu_half_issue_ctrl: hazard vector table, hand sequences
// for the iterative corner cases, and a writeback scoreboard.
module tb_fpu_half_issue_ctrl;
  import fpu_half_pkg::*;

  localparam int LAT = 3;

  logic           CLK = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  fpu_operation_t req_op = FPU_HALF_ADD;
  logic [4:0]     req_rd = '0;
  logic [4:0]     req_rs1 = '0;
  logic [4:0]     req_rs2 = '0;
  logic [4:0]     req_rs3 = '0;
  logic           iter_done = 1'b0;
  logic           req_ready;
  logic           pipe_issue;
  logic [3:0]     pipe_op;
  logic           iter_start;
  logic           iter_sqrt;
  logic           wb_valid;
  logic [4:0]     wb_rd;
  logic           wb_sel;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  fpu_half_issue_ctrl #(.PIPE_LAT(LAT), .REG_W(5)) dut (
    .CLK(CLK), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rd(req_rd),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_rs3(req_rs3),
    .pipe_issue(pipe_issue), .pipe_op(pipe_op),
    .iter_start(iter_start), .iter_sqrt(iter_sqrt),
    .iter_done(iter_done),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_sel(wb_sel)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input fpu_operation_t op,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rs3);
    req_valid = 1'b1;
    req_op = op;
    req_rd = rd;
    req_rs1 = rs1;
    req_rs2 = rs2;
    req_rs3 = rs3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    iter_done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard: pipe results due LAT cycles after issue,
  // iterative results in start order.
  typedef struct {
    logic [4:0] rd;
    int         due;
  } pexp_t;
  pexp_t      pq[$];
  logic [4:0] iq[$];

  always @(posedge CLK) begin
    #3;
    if (rst) begin
      pq.delete();
      iq.delete();
    end else begin
      if (pq.size() > 0 && pq[0].due == cyc) begin
        chk("sb pipe wb_valid", wb_valid, 1);
        chk("sb pipe wb_sel", wb_sel, 0);
        chk("sb pipe wb_rd", wb_rd, pq[0].rd);
        void'(pq.pop_front());
      end else begin
        chk("sb no pipe wb", wb_valid & ~wb_sel, 0);
      end
      if (wb_valid && wb_sel) begin
        if (iq.size() == 0)
          chk("sb iter wb unexpected", wb_valid, 0);
        else begin
          chk("sb iter wb_rd", wb_rd, iq[0]);
          void'(iq.pop_front());
        end
      end
      if (pipe_issue) pq.push_back('{req_rd, cyc + LAT});
      if (iter_start) iq.push_back(req_rd);
    end
  end

  typedef struct {
    string          name;
    fpu_operation_t op0;
    logic [4:0]     rd0;
    int             k;
    fpu_operation_t op1;
    logic [4:0]     rd1, rs1, rs2, rs3;
    logic           rdy;
  } vec_t;

  vec_t tv[13];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{"raw rs1 stage0", FPU_HALF_MUL, 4, 1, FPU_HALF_ADD, 9, 4, 2, 0, 0};
    tv[1]  = '{"raw rs1 tail", FPU_HALF_MUL, 4, 3, FPU_HALF_ADD, 9, 4, 2, 0, 0};
    tv[2]  = '{"raw cleared", FPU_HALF_MUL, 4, 4, FPU_HALF_ADD, 9, 4, 2, 0, 1};
    tv[3]  = '{"waw pipe", FPU_HALF_MUL, 4, 1, FPU_HALF_ADD, 4, 1, 2, 0, 0};
    tv[4]  = '{"rs3 ignored add", FPU_HALF_MUL, 4, 2, FPU_HALF_ADD, 9, 1, 2, 4, 1};
    tv[5]  = '{"rs3 madd", FPU_HALF_MUL, 4, 2, FPU_HALF_MADD, 9, 1, 2, 4, 0};
    tv[6]  = '{"rs3 nmsub", FPU_HALF_MUL, 4, 2, FPU_HALF_NMSUB, 9, 1, 2, 4, 0};
    tv[7]  = '{"raw rs2 iter", FPU_HALF_DIV, 5, 1, FPU_HALF_ADD, 9, 1, 5, 0, 0};
    tv[8]  = '{"pipe during div", FPU_HALF_DIV, 5, 1, FPU_HALF_ADD, 7, 1, 2, 0, 1};
    tv[9]  = '{"iter busy", FPU_HALF_DIV, 5, 1, FPU_HALF_SQRT, 6, 1, 0, 0, 0};
    tv[10] = '{"x0 no hazard", FPU_HALF_MUL, 0, 1, FPU_HALF_ADD, 0, 0, 0, 0, 1};
    tv[11] = '{"iter while pipe", FPU_HALF_ADD, 2, 1, FPU_HALF_DIV, 6, 1, 3, 0, 1};
    tv[12] = '{"waw iter", FPU_HALF_SQRT, 5, 2, FPU_HALF_ADD, 5, 1, 2, 0, 0};

    repeat (2) @(posedge CLK);
    #1;
    rst = 1'b0;
    #1;
    chk("reset req_ready", req_ready, 1);
    chk("reset pipe_issue", pipe_issue, 0);
    chk("reset iter_start", iter_start, 0);
    chk("reset wb_valid", wb_valid, 0);
    chk("reset wb_rd", wb_rd, 0);
    chk("reset wb_sel", wb_sel, 0);
    drive(FPU_HALF_SQRT, 1, 2, 0, 0);
    #1;
    chk("reset ready iter", req_ready, 1);
    chk("sqrt flag", iter_sqrt, 1);
    req_valid = 1'b0;
    tick();

    foreach (tv[i]) begin
      do_reset();
      drive(tv[i].op0, tv[i].rd0, 0, 0, 0);
      #1;
      chk({tv[i].name, " first"}, req_ready, 1);
      tick();
      req_valid = 1'b0;
      repeat (tv[i].k - 1) tick();
      drive(tv[i].op1, tv[i].rd1, tv[i].rs1,
            tv[i].rs2, tv[i].rs3);
      #1;
      chk(tv[i].name, req_ready, tv[i].rdy);
      req_valid = 1'b0;
      tick();
    end

    // Back-to-back FADD rd=1,2,3; scoreboard sees wb at 3,4,5.
    do_reset();
    for (int j = 0; j < 3; j++) begin
      drive(FPU_HALF_ADD, 5'(j + 1), 0, 0, 0);
      #1;
      chk("b2b ready", req_ready, 1);
      chk("b2b pipe_issue", pipe_issue, 1);
      chk("b2b pipe_op", pipe_op, FPU_HALF_ADD);
      tick();
    end
    req_valid = 1'b0;
    #1;
    chk("b2b wb3 rd", wb_rd, 1);
    repeat (4) tick();

    // Second DIV waits for first to write back.
    do_reset();
    drive(FPU_HALF_DIV, 5, 1, 2, 0);
    #1;
    chk("div1 iter_start", iter_start, 1);
    chk("div1 iter_sqrt", iter_sqrt, 0);
    chk("div1 pipe_issue", pipe_issue, 0);
    tick();
    for (int c = 1; c <= 11; c++) begin
      drive(FPU_HALF_DIV, 6, 1, 2, 0);
      iter_done = (c == 10);
      #1;
      chk("div2 stall", req_ready, 0);
      if (c == 11) begin
        chk("div1 wb_valid", wb_valid, 1);
        chk("div1 wb_sel", wb_sel, 1);
        chk("div1 wb_rd", wb_rd, 5);
      end
      tick();
    end
    iter_done = 1'b0;
    drive(FPU_HALF_DIV, 6, 1, 2, 0);
    #1;
    chk("div2 ready", req_ready, 1);
    chk("div2 iter_start", iter_start, 1);
    tick();
    req_valid = 1'b0;
    iter_done = 1'b1;
    tick();
    iter_done = 1'b0;
    repeat (2) tick();

    // iter_done collides with pipe tail; pipe wins.
    do_reset();
    drive(FPU_HALF_DIV, 5, 1, 2, 0);
    tick();
    req_valid = 1'b0;
    repeat (6) tick();
    drive(FPU_HALF_ADD, 7, 1, 2, 0);
    #1;
    chk("clash add7 ready", req_ready, 1);
    tick();
    drive(FPU_HALF_ADD, 8, 1, 2, 0);
    #1;
    chk("clash add8 ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    tick();
    iter_done = 1'b1;
    #1;
    chk("clash c10 wb_rd", wb_rd, 7);
    chk("clash c10 wb_sel", wb_sel, 0);
    tick();
    iter_done = 1'b0;
    drive(FPU_HALF_ADD, 9, 1, 2, 0);
    #1;
    chk("done_wait stall c11", req_ready, 0);
    chk("clash c11 wb_rd", wb_rd, 8);
    chk("clash c11 wb_sel", wb_sel, 0);
    tick();
    #1;
    chk("done_wait stall c12", req_ready, 0);
    chk("clash c12 wb_sel", wb_sel, 1);
    chk("clash c12 wb_rd", wb_rd, 5);
    tick();
    #1;
    chk("add9 ready c13", req_ready, 1);
    tick();
    req_valid = 1'b0;
    repeat (4) tick();

    // FMADD rs3 hazard against in-flight DIV.
    do_reset();
    drive(FPU_HALF_DIV, 5, 1, 2, 0);
    tick();
    drive(FPU_HALF_MADD, 8, 1, 2, 5);
    #1;
    chk("madd rs3 stall", req_ready, 0);
    tick();
    drive(FPU_HALF_ADD, 9, 1, 2, 5);
    #1;
    chk("add rs3 free", req_ready, 1);
    tick();
    drive(FPU_HALF_MADD, 8, 1, 2, 5);
    iter_done = 1'b1;
    #1;
    chk("madd stall busy", req_ready, 0);
    tick();
    iter_done = 1'b0;
    #1;
    chk("madd stall wb", req_ready, 0);
    chk("madd div wb_sel", wb_sel, 1);
    tick();
    #1;
    chk("madd ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    repeat (4) tick();

    // Reset with work in flight; late iter_done ignored.
    do_reset();
    drive(FPU_HALF_ADD, 1, 0, 0, 0);
    tick();
    drive(FPU_HALF_ADD, 2, 0, 0, 0);
    tick();
    drive(FPU_HALF_DIV, 5, 0, 0, 0);
    tick();
    do_reset();
    req_op = FPU_HALF_ADD;
    req_rd = 1;
    for (int c = 4; c <= 7; c++) begin
      iter_done = (c == 5);
      #1;
      chk("post-rst wb_valid", wb_valid, 0);
      chk("post-rst ready", req_ready, 1);
      tick();
    end
    iter_done = 1'b0;
    drive(FPU_HALF_DIV, 5, 1, 2, 0);
    #1;
    chk("post-rst idle", req_ready, 1);
    chk("post-rst wb_valid", wb_valid, 0);
    req_valid = 1'b0;
    tick();
    tick();

    chk("pipe sb empty", pq.size(), 0);
    chk("iter sb empty", iq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
